ffsr_pulse_decoder: RTL
=======================

# ffsr_pulse_decoder

Receive-side counterpart of the pulse encoder: samples a serial pulse line over a fixed window of `INPUT_SIZE` cycles and converts it back to a binary pulse count. The count is presented on a valid/ready output port. It sits between a pulse-encoded spike channel and the binary neuron/synapse logic that consumes decoded values. An optional first-pulse-time capture supports temporal-code consumers.

## Interface
- `INPUT_SIZE`, 16: window length in cycles; also the maximum decodable count.
- `CNT_W`, `$clog2(INPUT_SIZE+1)`: width of count outputs. Derived; do not override.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a decode window; honoured only in IDLE.
- `clear`  input  1  synchronous abort; returns to IDLE and discards the result.
- `pulse`  input  1  serial pulse line; one sample per window cycle.
- `out_ready`  input  1  consumer accepts result.
- `out_valid`  output  1  result available.
- `count`  output  CNT_W  number of window cycles with `pulse`=1.
- `busy`  output  1  high in WINDOW or DONE.
- `first_time`  output  CNT_W  window index of the first pulse. Exists only with `FFSR_PULSE_FIRST_EN`.
- `first_vld`  output  1  at least one pulse seen. Exists only with `FFSR_PULSE_FIRST_EN`.

## Operation
- States: IDLE, WINDOW, DONE. Reset enters IDLE.
- IDLE:
  - `start`=1 → WINDOW.
  - Clears the accumulator and window index `t` to 0.
- WINDOW:
  - Each cycle, `pulse` is sampled at index `t`.
  - Accumulator increments when `pulse`=1.
  - `t` increments each cycle.
  - At `t`=INPUT_SIZE-1, the final sample is included and the state → DONE.
- DONE:
  - `out_valid`=1; `count` holds the final total.
  - `count` (and first-time outputs) are stable until the handshake.
  - `out_valid && out_ready` → IDLE.
- `start` is ignored outside IDLE. It is not queued.
- `clear`:
  - From any state → IDLE next edge; `out_valid` deasserts.
  - `clear` beats `start`, and beats a handshake in the same cycle.
- Arithmetic:
  - Accumulator is CNT_W bits. Maximum value is INPUT_SIZE, so it never wraps.
  - `t` counts 0..INPUT_SIZE-1 and wraps to 0 only on exit from WINDOW.
- Async reset mid-window or mid-DONE: immediate return to IDLE and all outputs 0. There is no partial result.

## Timing
- Reset values: `out_valid`=0, `count`=0, `busy`=0, `first_time`=0, `first_vld`=0.
- `start` sampled at edge E0. Window samples `pulse` at edges E1..E_INPUT_SIZE.
- `out_valid` rises after edge E_INPUT_SIZE.
- Start-to-valid latency: INPUT_SIZE cycles after the start edge (16 for the default).
- `busy` rises after E0 and falls after the handshake or `clear` edge.
- Minimum period between windows: INPUT_SIZE+2 cycles.
  - `start` is accepted in the cycle after the handshake, never in the same cycle.
- `count` is registered: no combinational path from `pulse` to any output.
- `out_valid` does not depend on `out_ready`.

## Configuration
- `FFSR_PULSE_FIRST_EN` defined:
  - Adds a first-pulse register set in WINDOW on the first `pulse`=1.
  - `first_time`=`t` of that sample; `first_vld`=1.
  - Both are cleared in IDLE and held through DONE.
  - No pulse in the window → `first_vld`=0, `first_time`=0.
- `FFSR_PULSE_FIRST_EN` undefined:
  - Ports and registers are absent.
  - Count behaviour is identical.

## Structure
- Shared package `ffsr_pulse_pkg`:
  - State enum typedef `pdec_state_t`.
  - Default window-size constant, shared with the encoder.
- One sub-module `ffsr_pulse_window_ctr`:
  - Window index counter.
  - Inputs: `load` and `en`. Outputs: `t` and `last`.
  - Reused by the encoder bench.

## Test plan
- Reset: assert `rst`=0 mid-stream → all outputs 0 immediately; release; `busy`=0 and `out_valid`=0.
- Pulses at window indices 0,3,4,9,15 with `out_ready`=1 → `out_valid` for exactly one cycle, 16 cycles after start, with `count`=5; then IDLE.
- Extremes: all 16 samples high → `count`=16, no wrap. No pulses → `count`=0, `out_valid` still asserted.
- Backpressure: `out_ready`=0 for 3 cycles in DONE plus a `start` pulse there → `count` stable, `start` ignored; `out_ready`=1 → IDLE; next `start` accepted the following cycle.
- `clear` at window index 8, with `start` high in the same cycle → IDLE next edge, no `out_valid`, `busy`=0.
- With `FFSR_PULSE_FIRST_EN`:
  - First pulse at index 3 then index 7 → `first_time`=3, `first_vld`=1, `count`=2.
  - No pulses → `first_vld`=0, `first_time`=0.

Source files
------------

// File: rtl/ffsr_pulse_pkg.sv
// Shared definitions for the pulse encoder/decoder pair: decoder state type,
// default window length and an index-width helper.
package ffsr_pulse_pkg;

  localparam int PULSE_INPUT_SIZE = 16;

  typedef enum logic [1:0] {
    PDEC_IDLE   = 2'd0,
    PDEC_WINDOW = 2'd1,
    PDEC_DONE   = 2'd2
  } pdec_state_t;

  // Width of a 0..n-1 index; at least one bit so a 1-cycle window still works.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ffsr_pulse_window_ctr.sv
// Window index counter: a down-counter of remaining samples with a terminal-count
// compare; t is presented as the up-counting sample index 0..SIZE-1.
module ffsr_pulse_window_ctr
  import ffsr_pulse_pkg::*;
#(
  parameter  int SIZE = PULSE_INPUT_SIZE,
  localparam int T_W  = idx_width(SIZE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           en,
  output logic [T_W-1:0] t,
  output logic           last
);

  localparam logic [T_W-1:0] T_MAX = T_W'(SIZE - 1);

  logic [T_W-1:0] rem;

  // Reloads itself on the terminal count so t reads 0 again after the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= T_MAX;
    end else if (load) begin
      rem <= T_MAX;
    end else if (en) begin
      rem <= (rem == '0) ? T_MAX : rem - T_W'(1);
    end
  end

  assign last = (rem == '0);
  assign t    = T_MAX - rem;

endmodule

// File: rtl/ffsr_pulse_decoder.sv
// Pulse-count decoder: counts pulse samples over an INPUT_SIZE-cycle window and
// offers the total on a valid/ready port. FFSR_PULSE_FIRST_EN adds first-pulse capture.
//
//   state  | meaning
//   IDLE   | waiting for start; accumulator and window index held at 0
//   WINDOW | sampling pulse once per cycle at index t
//   DONE   | result presented with out_valid until handshake or clear
module ffsr_pulse_decoder
  import ffsr_pulse_pkg::*;
#(
  parameter  int INPUT_SIZE = PULSE_INPUT_SIZE,
  localparam int CNT_W      = $clog2(INPUT_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             pulse,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             busy
`ifdef FFSR_PULSE_FIRST_EN
  ,
  output logic [CNT_W-1:0] first_time,
  output logic             first_vld
`endif
);

  localparam int T_W = idx_width(INPUT_SIZE);

  pdec_state_t    state, state_nxt;
  logic [CNT_W-1:0] acc;
  logic           win_load;
  logic           win_en;
  logic           win_last;
`ifdef FFSR_PULSE_FIRST_EN
  logic [T_W-1:0] win_t;
`else
  logic [T_W-1:0] win_t_unused;
`endif

  assign win_load = (state == PDEC_IDLE) || clear;
  assign win_en   = (state == PDEC_WINDOW);

  ffsr_pulse_window_ctr #(
    .SIZE (INPUT_SIZE)
  ) u_window_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (win_load),
    .en   (win_en),
`ifdef FFSR_PULSE_FIRST_EN
    .t    (win_t),
`else
    .t    (win_t_unused),
`endif
    .last (win_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PDEC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PDEC_IDLE:   if (start)     state_nxt = PDEC_WINDOW;
      PDEC_WINDOW: if (win_last)  state_nxt = PDEC_DONE;
      PDEC_DONE:   if (out_ready) state_nxt = PDEC_IDLE;
      default:                    state_nxt = PDEC_IDLE;
    endcase
    // clear overrides both start and the output handshake
    if (clear) state_nxt = PDEC_IDLE;
  end

  // Accumulator is CNT_W wide so a full window of pulses cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (win_load) begin
      acc <= '0;
    end else if (win_en && pulse) begin
      acc <= acc + CNT_W'(1);
    end
  end

`ifdef FFSR_PULSE_FIRST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_time <= '0;
      first_vld  <= 1'b0;
    end else if (win_load) begin
      first_time <= '0;
      first_vld  <= 1'b0;
    end else if (win_en && pulse && !first_vld) begin
      first_time <= CNT_W'(win_t);
      first_vld  <= 1'b1;
    end
  end
`endif

  assign count     = acc;
  assign out_valid = (state == PDEC_DONE);
  assign busy      = (state != PDEC_IDLE);

endmodule
